mem_access_unit: RTL

MEM-stage data-memory access controller for the RV32IM pipeline. It sits directly downstream of the EX/MEM pipeline register. It consumes the ALU address, store data and the 4-bit read/write code, drives a req/ack data-memory port with aligned address, byte enables and lane-shifted write data, and returns the sign- or zero-extended load value toward MEM/WB. It stalls the pipeline while an access is outstanding and flags misaligned accesses.

---
 rtl/mem_access_unit_if.sv | 25 ++
 rtl/mem_access_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory request/ack port.
//   master (access unit): drives mem_req, mem_we, mem_be, mem_addr, mem_wdata;
//                         samples mem_ack, mem_rdata.
//   slave  (memory):      the mirror image.
// mem_req is held high until mem_ack. mem_rdata is valid only while mem_ack=1.
`timescale 1ns/1ps
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access controller (RV32IM).
//
// Takes the EX/MEM access code, ALU address and rs2 store data. It issues one
// request per aligned access on the memory port, stalls upstream until the
// access completes, and returns the extended load value toward MEM/WB.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   read_write_in[3:0] access code (LB/LH/LW/LBU/LHU/SB/SH/SW, else none)
//   addr_in[31:0]     effective address
//   store_data_in     rs2 store data
//   mem               memory port (mem_access_unit_if.master)
//   load_data_out     sign/zero-extended load result, held until next load
//   stall             hold upstream pipeline
//   misaligned        combinational flag for a misaligned access
//   bus_error         timeout abort flag
//
// Build option: define MEM_TIMEOUT_EN to abort a BUSY access after
// TIMEOUT_CYCLES cycles without ack. Without it, BUSY waits indefinitely
// and bus_error is tied to 0.
`timescale 1ns/1ps
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                read_write_in,
    input  logic [31:0]               addr_in,
    input  logic [31:0]               store_data_in,
    mem_access_unit_if.master         mem,
    output logic [31:0]               load_data_out,
    output logic                      stall,
    output logic                      misaligned,
    output logic                      bus_error
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Decoded access: size 0=byte, 1=half, 2=word; sx = sign-extend load.
    typedef struct packed {
        logic       ld;
        logic       st;
        logic [1:0] sz;
        logic       sx;
    } acc_t;

    state_t      state_q, state_d;
    acc_t        acc;
    logic        valid, align_ok, go;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] rshift, ext;
    logic        timeout_hit;

    logic        req_q, we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q, wdata_q, load_q;

    // ---------------- decode ----------------
    always_comb begin
        acc = '0;
        unique case (read_write_in)
            4'b1000: acc = '{ld: 1'b1, st: 1'b0, sz: 2'd0, sx: 1'b1}; // LB
            4'b1001: acc = '{ld: 1'b1, st: 1'b0, sz: 2'd1, sx: 1'b1}; // LH
            4'b1010: acc = '{ld: 1'b1, st: 1'b0, sz: 2'd2, sx: 1'b0}; // LW
            4'b1100: acc = '{ld: 1'b1, st: 1'b0, sz: 2'd0, sx: 1'b0}; // LBU
            4'b1101: acc = '{ld: 1'b1, st: 1'b0, sz: 2'd1, sx: 1'b0}; // LHU
            4'b0101: acc = '{ld: 1'b0, st: 1'b1, sz: 2'd0, sx: 1'b0}; // SB
            4'b0110: acc = '{ld: 1'b0, st: 1'b1, sz: 2'd1, sx: 1'b0}; // SH
            4'b0111: acc = '{ld: 1'b0, st: 1'b1, sz: 2'd2, sx: 1'b0}; // SW
            default: acc = '0;                                        // none/reserved
        endcase
    end

    assign valid = acc.ld | acc.st;

    always_comb begin
        align_ok = 1'b1;
        if (acc.sz == 2'd1)      align_ok = ~addr_in[0];
        else if (acc.sz == 2'd2) align_ok = (addr_in[1:0] == 2'b00);
    end

    assign go = valid & align_ok;

    // ---------------- store lane steering ----------------
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = store_data_in;
        if (acc.sz == 2'd0) begin
            be_d    = 4'b0001 << addr_in[1:0];
            wdata_d = {4{store_data_in[7:0]}};
        end else if (acc.sz == 2'd1) begin
            be_d    = 4'b0011 << addr_in[1:0];
            wdata_d = {2{store_data_in[15:0]}};
        end
    end

    // ---------------- load extraction ----------------
    // Upstream holds addr/code stable while stalled, so the byte offset is
    // still valid on the ack cycle.
    assign rshift = mem.mem_rdata >> {addr_in[1:0], 3'b000};

    always_comb begin
        ext = rshift;
        if (acc.sz == 2'd0)
            ext = acc.sx ? {{24{rshift[7]}}, rshift[7:0]} : {24'h0, rshift[7:0]};
        else if (acc.sz == 2'd1)
            ext = acc.sx ? {{16{rshift[15]}}, rshift[15:0]} : {16'h0, rshift[15:0]};
    end

    // ---------------- optional timeout ----------------
`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_q;
    logic             bus_err_q;

    // Abort on the TIMEOUT_CYCLES-th BUSY cycle that sees no ack.
    assign timeout_hit = (state_q == BUSY) && !mem.mem_ack &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else if (state_q == IDLE && go) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else if (timeout_hit) begin
            bus_err_q <= 1'b1;
        end else if (state_q == BUSY && !mem.mem_ack) begin
            cnt_q     <= cnt_q + 1'b1;
        end
    end

    assign bus_error = bus_err_q;
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
    assign bus_error      = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (go) state_d = BUSY;
            BUSY:    if (mem.mem_ack || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            load_q  <= 32'h0;
        end else begin
            unique case (state_q)
                IDLE: if (go) begin
                    req_q   <= 1'b1;
                    we_q    <= acc.st;
                    be_q    <= be_d;
                    addr_q  <= {addr_in[31:2], 2'b00};
                    wdata_q <= wdata_d;
                end
                BUSY: if (mem.mem_ack) begin
                    req_q <= 1'b0;
                    we_q  <= 1'b0;
                    if (acc.ld) load_q <= ext;
                end else if (timeout_hit) begin
                    req_q  <= 1'b0;
                    we_q   <= 1'b0;
                    load_q <= 32'h0;
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    // A misaligned access never reaches the bus; its result reads as zero
    // for as long as the offending code is held.
    assign misaligned    = !rst && valid && !align_ok;
    assign load_data_out = misaligned ? 32'h0 : load_q;
    assign stall         = !rst && ((state_q == IDLE && go) || state_q == BUSY);

endmodule
